// File: rtl/echo_pkg.sv
// Shared types and helpers for the echo requester: FSM state encoding,
// data width and saturating counter arithmetic.
package echo_pkg;

    localparam int ECHO_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } echo_state_e;

    // Sum of a and b clamped to the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        if (sum > lim) begin
            sat_add = lim[31:0];
        end else begin
            sat_add = sum[31:0];
        end
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] a, input int unsigned w);
        return sat_add(a, 32'd1, w);
    endfunction

endpackage

// File: rtl/echo_sb_fifo.sv
// In-order scoreboard of outstanding echo request values: DEPTH-entry
// circular FIFO with wrapping pointers, occupancy count and synchronous flush.
module echo_sb_fifo
    import echo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ECHO_DATA_W-1:0]   push_v,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [ECHO_DATA_W-1:0]   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_DEPTH = (AW + 1)'(DEPTH);

    logic [ECHO_DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wr_q;
    logic [AW-1:0]          rd_q;
    logic [AW:0]            cnt_q;
    logic                   pop_ok_s;
    logic                   push_ok_s;

    assign full      = (cnt_q == CNT_DEPTH);
    assign empty     = (cnt_q == {(AW + 1){1'b0}});
    assign head      = mem_q[rd_q];
    assign count     = cnt_q;
    assign pop_ok_s  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still safe.
    assign push_ok_s = push & (~full | pop_ok_s);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {ECHO_DATA_W{1'b0}};
            end
            wr_q  <= {AW{1'b0}};
            rd_q  <= {AW{1'b0}};
            cnt_q <= {(AW + 1){1'b0}};
        end else if (flush) begin
            wr_q  <= {AW{1'b0}};
            rd_q  <= {AW{1'b0}};
            cnt_q <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_q[wr_q] <= push_v;
                wr_q        <= wr_q + {{(AW - 1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_q <= rd_q + {{(AW - 1){1'b0}}, 1'b1};
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_q <= cnt_q + {{AW{1'b0}}, 1'b1};
                2'b01:   cnt_q <= cnt_q - {{AW{1'b0}}, 1'b1};
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/echo_requester.sv
// Echo interface initiator: issues a burst of incrementing request values and
// checks the returned indications in order. Optional watchdog: ECHO_REQUESTER_TIMEOUT_EN.
module echo_requester
    import echo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
`ifdef ECHO_REQUESTER_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start__ENA,
    output logic                   start__RDY,
    input  logic [CNT_W-1:0]       start_count,
    input  logic [ECHO_DATA_W-1:0] start_seed,
    output logic                   echoReq__ENA,
    output logic [ECHO_DATA_W-1:0] echoReq_v,
    input  logic                   echoReq__RDY,
    input  logic                   ind_echo__ENA,
    input  logic [ECHO_DATA_W-1:0] ind_echo_v,
    output logic                   ind_echo__RDY,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       sent_count,
    output logic [CNT_W-1:0]       recv_count,
    output logic [CNT_W-1:0]       err_count,
    output logic [ECHO_DATA_W-1:0] last_bad_v
`ifdef ECHO_REQUESTER_TIMEOUT_EN
    , output logic                 timeout
`endif
);

    localparam int SB_CW = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W - 1){1'b0}}, 1'b1};

    echo_state_e            state_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       sent_q;
    logic [CNT_W-1:0]       recv_q;
    logic [CNT_W-1:0]       err_q;
    logic [ECHO_DATA_W-1:0] seed_q;
    logic [ECHO_DATA_W-1:0] last_bad_q;
    logic                   rdy_q;

    logic                   sb_full_s;
    logic                   sb_empty_s;
    logic [ECHO_DATA_W-1:0] sb_head_s;
    logic [SB_CW-1:0]       sb_count_s;
    logic                   start_s;
    logic                   issue_s;
    logic                   resp_live_s;
    logic                   sb_pop_s;
    logic                   bad_s;
    logic                   wd_fire_s;

    assign start__RDY    = (state_q == IDLE) || (state_q == DONE);
    assign start_s       = start__ENA & start__RDY;
    assign issue_s       = (state_q == RUN) & (sent_q < count_q) & ~sb_full_s & echoReq__RDY & ~wd_fire_s;
    assign echoReq__ENA  = issue_s;
    assign echoReq_v     = seed_q + ECHO_DATA_W'(sent_q);
    // Responses are only scored once a burst has been started; stragglers seen in IDLE are dropped.
    assign resp_live_s   = ind_echo__ENA & (state_q != IDLE) & ~start_s & ~wd_fire_s;
    assign sb_pop_s      = resp_live_s & ~sb_empty_s;
    assign bad_s         = resp_live_s & (sb_empty_s | (sb_head_s != ind_echo_v));

    assign ind_echo__RDY = rdy_q;
    assign busy          = (state_q == RUN) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign sent_count    = sent_q;
    assign recv_count    = recv_q;
    assign err_count     = err_q;
    assign last_bad_v    = last_bad_q;

`ifdef ECHO_REQUESTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_q;
    logic            to_q;

    assign wd_fire_s = busy & (wd_q == WD_LIMIT);
    assign timeout   = to_q;

    // Watchdog: counts stalled cycles while responses are owed.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wd_q <= {WD_W{1'b0}};
            to_q <= 1'b0;
        end else begin
            if (start_s || issue_s || sb_pop_s || !busy || wd_fire_s) begin
                wd_q <= {WD_W{1'b0}};
            end else if (!sb_empty_s) begin
                wd_q <= wd_q + {{(WD_W - 1){1'b0}}, 1'b1};
            end else begin
                wd_q <= {WD_W{1'b0}};
            end
            if (start_s) begin
                to_q <= 1'b0;
            end else if (wd_fire_s) begin
                to_q <= 1'b1;
            end else begin
                to_q <= to_q;
            end
        end
    end
`else
    assign wd_fire_s = 1'b0;
`endif

    echo_sb_fifo #(
        .DEPTH (DEPTH)
    ) u_sb (
        .clk    (CLK),
        .rst    (RST),
        .push   (issue_s),
        .push_v (echoReq_v),
        .pop    (sb_pop_s),
        .flush  (wd_fire_s),
        .full   (sb_full_s),
        .empty  (sb_empty_s),
        .head   (sb_head_s),
        .count  (sb_count_s)
    );

    // Burst FSM with its counters and error capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            count_q    <= CNT_ZERO;
            seed_q     <= {ECHO_DATA_W{1'b0}};
            sent_q     <= CNT_ZERO;
            recv_q     <= CNT_ZERO;
            err_q      <= CNT_ZERO;
            last_bad_q <= {ECHO_DATA_W{1'b0}};
            rdy_q      <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (start_s) begin
                count_q    <= start_count;
                seed_q     <= start_seed;
                sent_q     <= CNT_ZERO;
                recv_q     <= CNT_ZERO;
                err_q      <= CNT_ZERO;
                last_bad_q <= {ECHO_DATA_W{1'b0}};
                state_q    <= (start_count == CNT_ZERO) ? DONE : RUN;
            end else if (wd_fire_s) begin
                err_q   <= CNT_W'(sat_add(32'(err_q), 32'(sb_count_s), CNT_W));
                state_q <= DONE;
            end else begin
                if (issue_s) begin
                    sent_q <= sent_q + CNT_ONE;
                end
                if (sb_pop_s) begin
                    recv_q <= recv_q + CNT_ONE;
                end
                if (bad_s) begin
                    err_q      <= CNT_W'(sat_inc(32'(err_q), CNT_W));
                    last_bad_q <= ind_echo_v;
                end
                case (state_q)
                    RUN: begin
                        if ((sent_q == count_q) || (issue_s && ((sent_q + CNT_ONE) == count_q))) begin
                            state_q <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if ((recv_q == count_q) && (sb_count_s == SB_CW'(0))) begin
                            state_q <= DONE;
                        end
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_echo_requester.sv
// Self-checking bench for echo_requester: table of loopback bursts plus
// hand-written backpressure, zero-length, stray-response and reset sequences.
module tb_echo_requester;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RST;
    logic             start__ENA;
    logic             start__RDY;
    logic [CNT_W-1:0] start_count;
    logic [31:0]      start_seed;
    logic             echoReq__ENA;
    logic [31:0]      echoReq_v;
    logic             echoReq__RDY;
    logic             ind_echo__ENA;
    logic [31:0]      ind_echo_v;
    logic             ind_echo__RDY;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent_count;
    logic [CNT_W-1:0] recv_count;
    logic [CNT_W-1:0] err_count;
    logic [31:0]      last_bad_v;
`ifdef ECHO_REQUESTER_TIMEOUT_EN
    logic             timeout;
`endif

    echo_requester #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .start__ENA    (start__ENA),
        .start__RDY    (start__RDY),
        .start_count   (start_count),
        .start_seed    (start_seed),
        .echoReq__ENA  (echoReq__ENA),
        .echoReq_v     (echoReq_v),
        .echoReq__RDY  (echoReq__RDY),
        .ind_echo__ENA (ind_echo__ENA),
        .ind_echo_v    (ind_echo_v),
        .ind_echo__RDY (ind_echo__RDY),
        .busy          (busy),
        .done          (done),
        .sent_count    (sent_count),
        .recv_count    (recv_count),
        .err_count     (err_count),
        .last_bad_v    (last_bad_v)
`ifdef ECHO_REQUESTER_TIMEOUT_EN
        , .timeout     (timeout)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [CNT_W-1:0] count;
        logic [31:0]      seed;
        int               corrupt_at;
        bit               toggle_rdy;
        logic [CNT_W-1:0] exp_err;
        logic [31:0]      exp_bad;
    } vec_t;

    vec_t        vecs [4];
    logic [31:0] exp_q [$];
    logic [31:0] pend [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_issued = 0;
    int          tick_cnt = 0;
    int          resp_idx = 0;
    int          corrupt_at = -1;
    bit          rsp_en = 1'b1;
    bit          rdy_cfg = 1'b1;
    bit          toggle_rdy = 1'b0;
    bit          drop_first = 1'b0;
    bit          stray_en = 1'b0;
    logic [31:0] stray_v = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: drive responder and ready, score any issued request, advance to next negedge.
    task automatic tick();
        logic [31:0] v;
        ind_echo__ENA = 1'b0;
        ind_echo_v    = 32'd0;
        if (stray_en) begin
            ind_echo__ENA = 1'b1;
            ind_echo_v    = stray_v;
            stray_en      = 1'b0;
        end else if (rsp_en && pend.size() > 0) begin
            v = pend.pop_front();
            if (resp_idx == corrupt_at) v = 32'h0000DEAD;
            resp_idx++;
            if (!(drop_first && resp_idx == 1)) begin
                ind_echo__ENA = 1'b1;
                ind_echo_v    = v;
            end
        end
        echoReq__RDY = toggle_rdy ? ((tick_cnt % 2) == 1) : rdy_cfg;
        tick_cnt++;
        #1;
        if (echoReq__ENA) begin
            n_issued++;
            pend.push_back(echoReq_v);
            if (exp_q.size() == 0) check("req_extra", 32'd1, 32'd0);
            else check("req_v", echoReq_v, exp_q.pop_front());
        end
        @(negedge CLK);
    endtask

    task automatic start_burst(input logic [CNT_W-1:0] cnt, input logic [31:0] seed);
        for (int i = 0; i < int'(cnt); i++) exp_q.push_back(seed + 32'(i));
        resp_idx    = 0;
        n_issued    = 0;
        start__ENA  = 1'b1;
        start_count = cnt;
        start_seed  = seed;
        check("start_rdy", 32'(start__RDY), 32'd1);
        tick();
        start__ENA  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++) tick();
        check("done", 32'(done), 32'd1);
    endtask

    initial begin
        vecs[0] = '{count: 16'd8, seed: 32'h10,       corrupt_at: -1, toggle_rdy: 1'b0, exp_err: 16'd0, exp_bad: 32'h0};
        vecs[1] = '{count: 16'd5, seed: 32'h100,      corrupt_at: 2,  toggle_rdy: 1'b0, exp_err: 16'd1, exp_bad: 32'hDEAD};
        vecs[2] = '{count: 16'd4, seed: 32'hFFFFFFFE, corrupt_at: -1, toggle_rdy: 1'b0, exp_err: 16'd0, exp_bad: 32'h0};
        vecs[3] = '{count: 16'd7, seed: 32'h5,        corrupt_at: -1, toggle_rdy: 1'b1, exp_err: 16'd0, exp_bad: 32'h0};

        RST = 1'b1; start__ENA = 1'b0; start_count = '0; start_seed = 32'd0;
        echoReq__RDY = 1'b0; ind_echo__ENA = 1'b0; ind_echo_v = 32'd0;
        repeat (2) @(negedge CLK);
        check("rst_ind_rdy", 32'(ind_echo__RDY), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req_en", 32'(echoReq__ENA), 32'd0);
        check("rst_req_v", echoReq_v, 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_start_rdy", 32'(start__RDY), 32'd1);
        RST = 1'b0;
        @(negedge CLK);
        check("ind_rdy_after_rst", 32'(ind_echo__RDY), 32'd1);

        stray_en = 1'b1; stray_v = 32'h1234;
        tick();
        check("idle_stray_err", 32'(err_count), 32'd0);

        foreach (vecs[k]) begin
            corrupt_at = vecs[k].corrupt_at;
            toggle_rdy = vecs[k].toggle_rdy;
            start_burst(vecs[k].count, vecs[k].seed);
            wait_done(200);
            check("vec_sent", 32'(sent_count), 32'(vecs[k].count));
            check("vec_recv", 32'(recv_count), 32'(vecs[k].count));
            check("vec_err", 32'(err_count), 32'(vecs[k].exp_err));
            check("vec_bad", last_bad_v, vecs[k].exp_bad);
            check("vec_all_issued", 32'(exp_q.size()), 32'd0);
            check("vec_busy", 32'(busy), 32'd0);
        end
        corrupt_at = -1; toggle_rdy = 1'b0;

        rsp_en = 1'b0;
        start_burst(16'd6, 32'h40);
        repeat (10) tick();
        check("hold_issued", 32'(n_issued), 32'd4);
        check("hold_sent", 32'(sent_count), 32'd4);
        echoReq__RDY = 1'b1; #1;
        check("hold_req_en", 32'(echoReq__ENA), 32'd0);
        rsp_en = 1'b1;
        wait_done(100);
        check("hold_sent_fin", 32'(sent_count), 32'd6);
        check("hold_recv_fin", 32'(recv_count), 32'd6);
        check("hold_err", 32'(err_count), 32'd0);

        start_burst(16'd0, 32'h77);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        stray_en = 1'b1; stray_v = 32'hBEEF;
        tick();
        check("stray_err", 32'(err_count), 32'd1);
        check("stray_bad", last_bad_v, 32'hBEEF);
        check("stray_recv", 32'(recv_count), 32'd0);

        rsp_en = 1'b0;
        start_burst(16'd2, 32'h200);
        repeat (4) tick();
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_sent", 32'(sent_count), 32'd2);
        RST = 1'b1; #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_sent", 32'(sent_count), 32'd0);
        check("arst_recv", 32'(recv_count), 32'd0);
        check("arst_ind_rdy", 32'(ind_echo__RDY), 32'd0);
        check("arst_req_v", echoReq_v, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        rsp_en = 1'b1;
        repeat (3) tick();
        check("late_resp_err", 32'(err_count), 32'd0);
        start_burst(16'd3, 32'h300);
        wait_done(100);
        check("post_rst_recv", 32'(recv_count), 32'd3);
        check("post_rst_err", 32'(err_count), 32'd0);

`ifdef ECHO_REQUESTER_TIMEOUT_EN
        drop_first = 1'b1;
        start_burst(16'd1, 32'h400);
        wait_done(1200);
        check("to_flag", 32'(timeout), 32'd1);
        check("to_err", 32'(err_count), 32'd1);
        drop_first = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/echo_requester.md
Name: echo_requester

Overview:
- Initiator end of the echo interface: issues echoReq method calls and consumes ind_echo indications returned by the echo responder.
- Generates a programmable burst of request values and keeps an in-order scoreboard of outstanding values.
- Checks each returned value against its request and reports counts, errors and completion.
- Sits in the test/bring-up fabric facing the responder's request and indication ports.

Parameters:
- DEPTH, 4, maximum outstanding requests; power of two, 2..16.
- CNT_W, 16, width of burst length and status counters.
- TIMEOUT_CYCLES, 1024, idle-response cycles before abort (optional feature only).

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-high
- start__ENA  in  1  start a burst; honoured only when start__RDY=1
- start__RDY  out  1  high when in IDLE or DONE
- start_count  in  CNT_W  number of requests in the burst; 0 is legal
- start_seed  in  32  first request value
- echoReq__ENA  out  1  request issued this cycle
- echoReq_v  out  32  request value
- echoReq__RDY  in  1  responder can accept a request
- ind_echo__ENA  in  1  response valid this cycle
- ind_echo_v  in  32  response value
- ind_echo__RDY  out  1  always 1 out of reset
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- sent_count  out  CNT_W  requests issued in the current burst
- recv_count  out  CNT_W  responses accepted in the current burst
- err_count  out  CNT_W  mismatches plus unexpected responses; saturates at all-ones
- last_bad_v  out  32  most recent offending response value

Behaviour:
- Reset (asynchronous): state IDLE; all counters, scoreboard pointers, last_bad_v and echoReq_v cleared to 0; echoReq__ENA=0; done=0; busy=0; ind_echo__RDY=0 while RST is asserted, 1 thereafter.
- FSM IDLE -> RUN on start__ENA & start__RDY:
  - latch start_count and start_seed;
  - clear sent_count, recv_count, err_count and last_bad_v.
  - If start_count=0: go directly to DONE the next cycle.
- RUN: echoReq__ENA = (sent_count < count) & !sb_full & echoReq__RDY.
  - echoReq__ENA and echoReq_v are combinational from registered state; latency 0 from echoReq__RDY.
  - echoReq_v = seed + sent_count, modulo 2^32; wraps from 0xFFFFFFFF to 0.
  - On issue: push echoReq_v into the scoreboard and increment sent_count.
  - RUN -> DRAIN once sent_count reaches count.
- DRAIN -> DONE when recv_count = count and the scoreboard is empty.
- DONE -> RUN on a new start, with the same latch and clear actions as from IDLE.
- Response handling, any state:
  - On ind_echo__ENA with the scoreboard non-empty: pop the head, increment recv_count, compare head with ind_echo_v; on mismatch increment err_count and load last_bad_v.
  - On ind_echo__ENA with the scoreboard empty (unexpected response): increment err_count, load last_bad_v; recv_count unchanged.
- Scoreboard: DEPTH-entry circular FIFO with wrapping pointers and an occupancy counter.
  - Simultaneous push and pop in one cycle is legal, including when full (pop frees the slot) and when empty (the pushed value cannot be popped in the same cycle, so the response counts as unexpected).
  - Never pushes when full.
- start__ENA while busy is ignored.
- RST mid-burst aborts immediately; in-flight responses arriving after reset count as unexpected only once a burst is running.

Optional Feature:
- Macro ECHO_REQUESTER_TIMEOUT_EN.
- Defined: a watchdog counter resets on any accepted response or issued request and increments while in RUN or DRAIN with the scoreboard non-empty. On reaching TIMEOUT_CYCLES:
  - go to DONE;
  - add the scoreboard occupancy to err_count (saturating);
  - flush the scoreboard;
  - drive an extra output port timeout (1 bit, cleared on start and on reset).
- Not defined: no watchdog, no timeout port; DRAIN waits indefinitely.

Decomposition:
- Shared package echo_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - ECHO_DATA_W=32;
  - a saturating-increment function.
- One sub-module: echo_sb_fifo (parameterised DEPTH x 32 circular FIFO exposing push, pop, full, empty, head, count).

Test Plan:
- Loopback responder with 1-cycle delay; start_count=8, seed=0x10 -> requests 0x10..0x17 in order; done after 8 responses; err_count=0.
- Hold echoReq__RDY=1 and withhold responses; DEPTH=4, count=6 -> exactly 4 issues, then echoReq__ENA=0; releasing responses lets the remaining 2 issue; final sent=recv=6.
- Responder corrupts the 3rd response to 0xDEAD, seed=0x100, count=5 -> err_count=1, last_bad_v=0xDEAD, recv_count=5, done=1.
- seed=0xFFFFFFFE, count=4 -> values 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; no errors.
- ind_echo__ENA pulse while IDLE after start with count=0 -> DONE next cycle; stray pulse -> err_count=1, last_bad_v equals the pulsed value.
- Assert RST during DRAIN with 2 outstanding -> all outputs 0 asynchronously; a new start with count=3 completes cleanly. With the macro enabled: a dropped response -> timeout=1 and err_count=1 after TIMEOUT_CYCLES.
